// File: rtl/pwm_audio_out.sv
// 1-bit audio output stage: one-deep sample buffer feeding a PWM or first-order
// sigma-delta modulator whose duty/mode only change at period boundaries.
module pwm_audio_out #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             mode,
    input  logic             clr_underrun,
    output logic             pwm_out,
    output logic             period_strobe,
    output logic             underrun
);

    localparam int unsigned ACC_W = WIDTH + 1;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] stage_q, stage_d;
    logic             stage_full_q, stage_full_d;
    logic             ready_q, ready_d;
    logic             mode_q, mode_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             pwm_q, pwm_d;
    logic             strobe_q, strobe_d;
    logic             underrun_q, underrun_d;

    logic             boundary_c;
    logic             xfer_c;
    logic [ACC_W-1:0] sd_sum_c;

    assign boundary_c = ena && (cnt_q == CNT_MAX);
    assign xfer_c     = sample_valid && !stage_full_q;
    // Accumulator keeps only its low WIDTH bits; the top bit is the emitted carry.
    assign sd_sum_c   = ACC_W'({1'b0, acc_q[WIDTH-1:0]}) + ACC_W'(duty_q);

    always_comb begin
        cnt_d        = cnt_q;
        duty_d       = duty_q;
        stage_d      = stage_q;
        stage_full_d = stage_full_q;
        mode_d       = mode_q;
        acc_d        = acc_q;
        pwm_d        = 1'b0;
        strobe_d     = 1'b0;
        underrun_d   = underrun_q;

        if (clr_underrun) begin
            underrun_d = 1'b0;
        end

        if (ena) begin
            cnt_d = cnt_q + WIDTH'(1);
            if (mode_q) begin
                acc_d = sd_sum_c;
                pwm_d = sd_sum_c[WIDTH];
            end else begin
                pwm_d = (cnt_q < duty_q);
            end
        end

        // Period boundary: swap in the buffered sample and latch the new mode.
        if (boundary_c) begin
            strobe_d = 1'b1;
            mode_d   = mode;
            if (mode != mode_q) begin
                acc_d = '0;
            end
            if (stage_full_q) begin
                duty_d       = stage_q;
                stage_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        // Only possible while the buffer is empty, so never races the load above.
        if (xfer_c) begin
            stage_d      = sample_in;
            stage_full_d = 1'b1;
        end
    end

    assign ready_d = ~stage_full_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            duty_q       <= '0;
            stage_q      <= '0;
            stage_full_q <= 1'b0;
            ready_q      <= 1'b1;
            mode_q       <= 1'b0;
            acc_q        <= '0;
            pwm_q        <= 1'b0;
            strobe_q     <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            duty_q       <= duty_d;
            stage_q      <= stage_d;
            stage_full_q <= stage_full_d;
            ready_q      <= ready_d;
            mode_q       <= mode_d;
            acc_q        <= acc_d;
            pwm_q        <= pwm_d;
            strobe_q     <= strobe_d;
            underrun_q   <= underrun_d;
        end
    end

    assign sample_ready  = ready_q;
    assign pwm_out       = pwm_q;
    assign period_strobe = strobe_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: queue-based reference model checked every cycle,
// plus per-period high-count literals for directed scenarios.
module tb_pwm_audio_out;

    localparam int unsigned W = 8;
    localparam int P = 256;

    logic         clk, rst_n, ena, sample_valid, mode, clr_underrun;
    logic [W-1:0] sample_in;
    logic         sample_ready, pwm_out, period_strobe, underrun;

    int n_chk = 0;
    int n_err = 0;

    pwm_audio_out #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .mode          (mode),
        .clr_underrun  (clr_underrun),
        .pwm_out       (pwm_out),
        .period_strobe (period_strobe),
        .underrun      (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: counter position, active duty, one-slot sample queue.
    int  m_cnt = 0, m_duty = 0, m_mode = 0, m_acc = 0, m_sum = 0;
    bit  m_pwm = 0, m_str = 0, m_und = 0, m_bnd = 0, m_empty = 1;
    int  m_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_duty = 0; m_mode = 0; m_acc = 0;
            m_pwm = 0; m_str = 0; m_und = 0;
            m_q.delete();
        end else begin
            m_bnd   = ena && (m_cnt == P - 1);
            m_empty = (m_q.size() == 0);
            m_str   = m_bnd;
            if (ena) begin
                if (m_mode == 1) begin
                    m_sum = (m_acc % P) + m_duty;
                    m_pwm = (m_sum >= P);
                    m_acc = m_sum;
                end else begin
                    m_pwm = (m_cnt < m_duty);
                end
                m_cnt = (m_cnt + 1) % P;
            end else begin
                m_pwm = 0;
            end
            if (clr_underrun) m_und = 0;
            if (m_bnd) begin
                if (!m_empty) m_duty = m_q.pop_front();
                else m_und = 1;
                if (int'(mode) != m_mode) m_acc = 0;
                m_mode = int'(mode);
            end
            if (sample_valid && m_empty) m_q.push_back(int'(sample_in));
        end
    end

    always @(negedge clk) begin
        chk("pwm_out", pwm_out, m_pwm);
        chk("period_strobe", period_strobe, m_str);
        chk("underrun", underrun, m_und);
        chk("sample_ready", sample_ready, m_q.size() == 0);
    end

    task automatic send(input logic [W-1:0] v);
        int n;
        n = 0;
        sample_in    = v;
        sample_valid = 1'b1;
        while (!sample_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("send_timeout", 0, 1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic arm(input logic [W-1:0] v);
        chk("arm_ready", sample_ready, 1);
        sample_in    = v;
        sample_valid = 1'b1;
    endtask

    task automatic wait_strobe();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            sample_valid = 1'b0;
            clr_underrun = 1'b0;
            n++;
        end while (!period_strobe && n < 600);
        if (!period_strobe) chk("strobe_timeout", 0, 1);
    endtask

    // Starts on a strobe cycle; covers one full period of output cycles.
    task automatic count_period(input string nm, input int exp_hi, input int exp_run,
                                input int mode_at, input logic mode_v);
        int hi, run, maxr;
        hi = 0; run = 0; maxr = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            clr_underrun = 1'b0;
            if (pwm_out) begin
                hi++; run++;
                if (run > maxr) maxr = run;
            end else begin
                run = 0;
            end
            if (i == mode_at) mode = mode_v;
        end
        chk(nm, hi, exp_hi);
        if (exp_run >= 0) chk("max_run", maxr, exp_run);
        chk("period_end_strobe", period_strobe, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, strobes;
        rst_n = 1'b1; ena = 1'b0; sample_valid = 1'b0; sample_in = '0;
        mode = 1'b0; clr_underrun = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready", sample_ready, 1);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_strobe", period_strobe, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;

        // First boundary with nothing buffered, then duty 0x40.
        wait_strobe();
        chk("first_underrun", underrun, 1);
        send(8'h40);
        wait_strobe();
        clr_underrun = 1'b1;
        count_period("hi_0x40", 64, 64, -1, 1'b0);

        // Backpressure: 0x10 waits behind 0x80.
        send(8'h80);
        sample_in    = 8'h10;
        sample_valid = 1'b1;
        @(negedge clk);
        chk("hold_ready", sample_ready, 0);
        send(8'h10);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        wait_strobe();
        chk("no_underrun", underrun, 0);
        count_period("hi_0x10", 16, 16, -1, 1'b0);

        // Duty extremes, then sigma-delta with a mid-period mode change.
        send(8'h00);
        wait_strobe();
        arm(8'hFF);
        count_period("hi_0x00", 0, 0, -1, 1'b0);
        arm(8'h03);
        mode = 1'b1;
        count_period("hi_0xFF", 255, 255, -1, 1'b0);
        arm(8'h03);
        count_period("sd_0x03", 3, 1, -1, 1'b0);
        arm(8'h03);
        count_period("sd_0x03_modechg", 3, 1, 100, 1'b0);
        arm(8'h40);
        count_period("pwm_0x03", 3, 3, -1, 1'b0);

        // ena dropped for 37 cycles mid-period.
        hi = 0; strobes = 0;
        for (int i = 0; i < P + 37; i++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (pwm_out) hi++;
            if (period_strobe) strobes++;
            if (i == 30) ena = 1'b0;
            if (i == 67) ena = 1'b1;
        end
        chk("ena_gap_hi", hi, 64);
        chk("ena_gap_strobes", strobes, 1);
        chk("ena_gap_end_strobe", period_strobe, 1);

        // Asynchronous reset with a sample buffered.
        send(8'h22);
        repeat (20) @(negedge clk);
        chk("pre_rst_underrun", underrun, 1);
        chk("pre_rst_pwm", pwm_out, 1);
        chk("pre_rst_ready", sample_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pwm", pwm_out, 0);
        chk("async_underrun", underrun, 0);
        chk("async_strobe", period_strobe, 0);
        chk("async_ready", sample_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
